// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// instruction_fetch_stage: RV64 PC register, byte-wide instruction memory and
// IF/ID pipeline register with stall and branch-redirect handling.
// Revision: 1.0
// ============================================================================
module instruction_fetch_stage #(
  parameter int          IMEM_BYTES = 64,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [63:0] fetch_pc,
  output logic [63:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out
);

  localparam int          AW          = $clog2(IMEM_BYTES);
  localparam logic [31:0] C_NOP       = 32'h0000_0013;
  localparam logic [63:0] C_MEM_SIZE  = 64'(IMEM_BYTES);
  localparam logic [63:0] C_LAST_WORD = 64'(IMEM_BYTES - 4);

  logic [7:0]    mem_q [IMEM_BYTES];
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   pc_out_q, pc_out_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] rd_idx;
  logic [31:0]   fetch_word;

  // Loader port is independent of reset so programs survive a pipeline reset
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < C_MEM_SIZE)) begin
      mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
    end
  end

  always_comb begin
    rd_idx     = fetch_pc_q[AW-1:0];
    fetch_word = C_NOP;
    if (fetch_pc_q <= C_LAST_WORD) begin
      fetch_word = {mem_q[rd_idx + AW'(3)], mem_q[rd_idx + AW'(2)],
                    mem_q[rd_idx + AW'(1)], mem_q[rd_idx]};
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (branch_taken) begin
      fetch_pc_d = branch_target & ~64'd3;
      pc_out_d   = 64'd0;
      instr_d    = C_NOP;
      valid_d    = 1'b0;
    end else if (!stall) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
      pc_out_d   = fetch_pc_q;
      instr_d    = fetch_word;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      pc_out_q   <= 64'd0;
      instr_q    <= C_NOP;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign fetch_pc        = fetch_pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch_stage: scoreboard bench for instruction_fetch_stage.
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch_stage;

  localparam int          IMEM_BYTES = 64;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_we;
  logic [63:0] branch_target, imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] fetch_pc, pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  instruction_fetch_stage #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .fetch_pc(fetch_pc), .pc_out(pc_out),
    .instruction_out(instruction_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fpc;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  bmem [IMEM_BYTES];
  logic [63:0] m_fpc, m_pc;
  logic [31:0] m_ins;
  logic        m_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [63:0] a);
    if (a > 64'(IMEM_BYTES - 4)) return C_NOP;
    return {bmem[a[5:0] + 6'd3], bmem[a[5:0] + 6'd2], bmem[a[5:0] + 6'd1], bmem[a[5:0]]};
  endfunction

  // Drive one cycle, predict the resulting state, then compare after the edge
  task automatic cycle(input logic rst_n, input logic st, input logic br, input logic [63:0] tgt,
                       input logic we, input logic [63:0] wa, input logic [7:0] wd);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = rst_n; stall = st; branch_taken = br; branch_target = tgt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    if (!rst_n) begin
      m_fpc = 64'd0; m_pc = 64'd0; m_ins = C_NOP; m_v = 1'b0;
    end else if (br) begin
      m_fpc = {tgt[63:2], 2'b00}; m_pc = 64'd0; m_ins = C_NOP; m_v = 1'b0;
    end else if (!st) begin
      m_pc = m_fpc; m_ins = model_word(m_fpc); m_v = 1'b1; m_fpc = m_fpc + 64'd4;
    end
    if (we && wa < 64'(IMEM_BYTES)) bmem[wa[5:0]] = wd;
    e.fpc = m_fpc; e.pc = m_pc; e.ins = m_ins; e.v = m_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      check_eq("sb_fetch_pc", fetch_pc, got.fpc);
      check_eq("sb_pc_out", pc_out, got.pc);
      check_eq("sb_instr", {32'd0, instruction_out}, {32'd0, got.ins});
      check_eq("sb_valid", {63'd0, valid_out}, {63'd0, got.v});
    end
  endtask

  task automatic run(input logic st, input logic br, input logic [63:0] tgt);
    cycle(1'b1, st, br, tgt, 1'b0, 64'd0, 8'd0);
  endtask

  initial begin
    logic [31:0] w0, w1;
    logic [7:0]  b;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    imem_we = 1'b0; imem_waddr = 64'd0; imem_wdata = 8'd0;
    w0 = 32'h00A0_0093;
    w1 = 32'h00B0_0113;

    // Preload while held in reset
    for (int a = 0; a < IMEM_BYTES; a++) begin
      if (a < 4)      b = w0[8*(a%4) +: 8];
      else if (a < 8) b = w1[8*(a%4) +: 8];
      else            b = 8'(a) ^ 8'hA5;
      cycle(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'(a), b);
    end
    check_eq("rst_fetch_pc", fetch_pc, 64'd0);
    check_eq("rst_instr", {32'd0, instruction_out}, {32'd0, C_NOP});
    check_eq("rst_valid", {63'd0, valid_out}, 64'd0);

    // T1
    run(1'b0, 1'b0, 64'd0);
    check_eq("t1_pc_out", pc_out, 64'd0);
    check_eq("t1_instr", {32'd0, instruction_out}, 64'h00A0_0093);
    check_eq("t1_valid", {63'd0, valid_out}, 64'd1);
    check_eq("t1_fetch_pc", fetch_pc, 64'd4);

    // T2: stall freezes everything
    run(1'b1, 1'b0, 64'd0);
    run(1'b1, 1'b0, 64'd0);
    check_eq("t2_frozen_fpc", fetch_pc, 64'd4);
    check_eq("t2_frozen_instr", {32'd0, instruction_out}, 64'h00A0_0093);
    run(1'b0, 1'b0, 64'd0);
    check_eq("t2_pc_out", pc_out, 64'd4);
    check_eq("t2_instr", {32'd0, instruction_out}, 64'h00B0_0113);
    check_eq("t2_fetch_pc", fetch_pc, 64'd8);

    // T5: write byte 8 while fetching it; old word captured
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'd8, 8'hFF);
    check_eq("t5_old_word", {32'd0, instruction_out}, 64'hAEAF_ACAD);
    cycle(1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'd64, 8'h77);

    // T3: redirect overrides stall
    run(1'b1, 1'b1, 64'h10);
    check_eq("t3_fetch_pc", fetch_pc, 64'h10);
    check_eq("t3_bubble_valid", {63'd0, valid_out}, 64'd0);
    check_eq("t3_bubble_instr", {32'd0, instruction_out}, {32'd0, C_NOP});
    run(1'b0, 1'b0, 64'd0);
    check_eq("t3_pc_out", pc_out, 64'h10);
    check_eq("t3_valid", {63'd0, valid_out}, 64'd1);

    // T5 continued: re-fetch byte 8
    run(1'b0, 1'b1, 64'd8);
    run(1'b0, 1'b0, 64'd0);
    check_eq("t5_new_word", {32'd0, instruction_out}, 64'hAEAF_ACFF);

    // T4: target alignment and out-of-range fetch
    run(1'b0, 1'b1, 64'h13);
    check_eq("t4_align", fetch_pc, 64'h10);
    run(1'b0, 1'b1, 64'h40);
    run(1'b0, 1'b0, 64'd0);
    check_eq("t4_oob_instr", {32'd0, instruction_out}, {32'd0, C_NOP});
    check_eq("t4_oob_valid", {63'd0, valid_out}, 64'd1);
    run(1'b0, 1'b1, 64'h3C);
    run(1'b0, 1'b0, 64'd0);
    check_eq("last_word", {32'd0, instruction_out}, 64'h9A9B_9899);

    // PC wraps at 2^64
    run(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run(1'b0, 1'b0, 64'd0);
    check_eq("wrap_fetch_pc", fetch_pc, 64'd0);
    check_eq("wrap_instr", {32'd0, instruction_out}, {32'd0, C_NOP});

    // Random mix; writes kept above byte 15 so T6 can re-read address 0
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
            64'($urandom_range(0, 79)), ($urandom_range(0, 3) == 0),
            64'($urandom_range(16, 70)), 8'($urandom));
    end

    // T6: reset beats stall and redirect
    cycle(1'b0, 1'b1, 1'b1, 64'h20, 1'b0, 64'd0, 8'd0);
    check_eq("t6_fetch_pc", fetch_pc, 64'd0);
    check_eq("t6_valid", {63'd0, valid_out}, 64'd0);
    run(1'b0, 1'b0, 64'd0);
    check_eq("t6_instr", {32'd0, instruction_out}, 64'h00A0_0093);
    check_eq("t6_pc_out", pc_out, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
